cpu_step_ctrl: RTL and testbench
================================

# cpu_step_ctrl

Parametrised run/step/breakpoint controller for the single-cycle CPU. It gates CPU execution through a per-cycle enable and replaces ad-hoc free-running clock toggling with host commands: halt, step N instructions, run, and clear. It captures the PC of every executed instruction into a trace FIFO. It sits between the host/bench and the CPU's `PC` output, and its `cpu_en` qualifies all CPU state updates.

## Interface
- `ADDR_W`, 32, PC/breakpoint width
- `STEP_W`, 16, step counter width
- `NUM_BP`, 2, breakpoint comparators (1..8)
- `TRACE_DEPTH`, 16, trace FIFO entries (power of two, ≥2)
- `CLK  in  1  sole clock, rising edge`
- `RST  in  1  asynchronous, active-high reset`
- `cmd_valid  in  1  command strobe`
- `cmd_ready  out  1  command accept; 1 whenever RST low`
- `cmd_op  in  2  0 HALT, 1 STEP, 2 RUN, 3 CLEAR`
- `cmd_count  in  STEP_W  instruction count for STEP`
- `bp_addr  in  NUM_BP*ADDR_W  breakpoint addresses, slot i at [i*ADDR_W +: ADDR_W]`
- `bp_en  in  NUM_BP  per-slot enable`
- `pc  in  ADDR_W  CPU program counter (instruction about to execute)`
- `cpu_en  out  1  CPU executes this cycle`
- `halted  out  1  state is IDLE`
- `halt_cause  out  2  0 NONE, 1 STEP_DONE, 2 BREAK, 3 HOST`
- `trace_valid  out  1  FIFO non-empty`
- `trace_ready  in  1  pop`
- `trace_pc  out  ADDR_W  head entry`
- `trace_count  out  $clog2(TRACE_DEPTH)+1  occupancy`
- `trace_overflow  out  1  sticky, an entry was dropped`

## Operation
- States: IDLE, STEP, RUN. Reset → IDLE. Outputs at reset: `cpu_en`=0, `halted`=1, `halt_cause`=0, FIFO empty, `trace_overflow`=0, `trace_valid`=0, `trace_count`=0.
- Accept = `cmd_valid & cmd_ready`. Commands are accepted in any state; the latest command wins.
  - HALT: → IDLE. Cause is HOST if the controller was running, unchanged otherwise.
  - STEP: counter ← `cmd_count`, → STEP. If `cmd_count`=0: stay/go IDLE, cause STEP_DONE, no execution.
  - RUN: → RUN.
  - CLEAR: flush FIFO, clear overflow, cause ← NONE. State is unchanged.
- `cpu_en` = (state≠IDLE) & ~`bp_hit`, combinational. `bp_hit` = any enabled slot with `bp_addr[i]==pc` and `skip`=0.
- `skip` is set on every STEP/RUN accept and clears after the first cycle with state≠IDLE. This lets execution resume past the breakpoint it stopped on.
- `bp_hit` in STEP/RUN: → IDLE, cause BREAK, no execution that cycle.
- STEP: the counter decrements each `cpu_en` cycle. On the cycle where it executes with counter=1: → IDLE, cause STEP_DONE.
- Trace push when `cpu_en`=1, data=`pc`. Pop when `trace_valid & trace_ready`.
- Push when full without a simultaneous pop: the entry is dropped and overflow is set. Push and pop together when full: both occur, no overflow.
- CLEAR with a simultaneous push: the FIFO ends empty and the push is discarded.

## Timing
- Command accepted at edge k → `cpu_en` reflects the new state from edge k until k+1.
- STEP N (no breakpoint) → exactly N consecutive `cpu_en` cycles. `halted` rises on the edge after the last one.
- HALT latency: zero further `cpu_en` cycles after the accepting edge.
- Trace entries are visible on `trace_pc` one cycle after the push. The FIFO is first-word-fall-through.
- RST asserted mid-operation: all outputs take reset values immediately (asynchronous). Counter and FIFO contents are discarded.

## Configuration
- `CPU_STEP_CTRL_TRACE_EN` defined: trace FIFO instantiated as specified.
- `CPU_STEP_CTRL_TRACE_EN` undefined: no FIFO storage. `trace_valid`, `trace_count`, `trace_overflow` and `trace_pc` are tied to 0, and `trace_ready` is ignored. Step/run/breakpoint behaviour is identical.

## Structure
- Package `cpu_step_ctrl_pkg` holds:
  - `cmd_op` constants (HALT/STEP/RUN/CLEAR)
  - `halt_cause` constants
  - FSM state encoding
- Sub-module `step_trace_fifo`, parametrised by width and depth: push/pop/flush, count, full/empty, sticky overflow.

## Test plan
- Reset, `pc` +4 per `cpu_en` from 0, STEP 3 → `cpu_en` high exactly 3 cycles; trace 0x0, 0x4, 0x8; `halted`=1; cause=1.
- `bp_addr[0]`=0x10 enabled, RUN → 4 executed cycles (0x0–0xC), `cpu_en` low at `pc`=0x10, cause=2. Then STEP 1 → executes 0x10, cause=1.
- `trace_ready`=0, STEP 20 → `trace_count`=16, overflow=1, pops yield 0x0–0x3C. CLEAR → count 0, overflow 0.
- RUN, HALT accepted 5 cycles later → exactly 5 `cpu_en` cycles, cause=3.
- STEP 10, RST asserted after 4 executed cycles → `cpu_en`=0 at once, FIFO empty, cause=0, `halted`=1.
- STEP 0 → no `cpu_en` cycle, cause=1. Repeat without `CPU_STEP_CTRL_TRACE_EN` → `trace_valid` stays 0 throughout.

Source files
------------

// File: rtl/cpu_step_ctrl_pkg.sv
// ============================================================================
// Module      : cpu_step_ctrl_pkg
// Description : Command opcodes, halt causes and FSM states for cpu_step_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_step_ctrl_pkg;

    localparam logic [1:0] C_OP_HALT  = 2'd0;
    localparam logic [1:0] C_OP_STEP  = 2'd1;
    localparam logic [1:0] C_OP_RUN   = 2'd2;
    localparam logic [1:0] C_OP_CLEAR = 2'd3;

    localparam logic [1:0] C_CAUSE_NONE      = 2'd0;
    localparam logic [1:0] C_CAUSE_STEP_DONE = 2'd1;
    localparam logic [1:0] C_CAUSE_BREAK     = 2'd2;
    localparam logic [1:0] C_CAUSE_HOST      = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/step_trace_fifo.sv
// ============================================================================
// Module      : step_trace_fifo
// Description : First-word-fall-through PC trace FIFO with flush and sticky
//               overflow; a push into a full FIFO without a pop is dropped.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module step_trace_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr;
    logic [AW:0]      r_rd;
    logic             r_overflow;
    logic             w_pop;
    logic             w_push_ok;

    assign o_count    = r_wr - r_rd;
    assign o_empty    = (r_wr == r_rd);
    assign o_full     = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign o_data     = r_mem[r_rd[AW-1:0]];
    assign o_overflow = r_overflow;

    assign w_pop     = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot, so a full-FIFO push still lands.
    assign w_push_ok = i_push & (~o_full | w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr       <= '0;
            r_rd       <= '0;
            r_overflow <= 1'b0;
        end else if (i_flush) begin
            r_wr       <= '0;
            r_rd       <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pop)
                r_rd <= r_rd + C_PTR_ONE;
            if (w_push_ok)
                r_wr <= r_wr + C_PTR_ONE;
            if (i_push & ~w_push_ok)
                r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok & ~i_flush)
            r_mem[r_wr[AW-1:0]] <= i_data;
    end

endmodule

`default_nettype wire

// File: rtl/cpu_step_ctrl.sv
// ============================================================================
// Module      : cpu_step_ctrl
// Description : Run/step/breakpoint controller gating the CPU via cpu_en, with
//               optional PC trace FIFO enabled by CPU_STEP_CTRL_TRACE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_step_ctrl
    import cpu_step_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int STEP_W      = 16,
    parameter int NUM_BP      = 2,
    parameter int TRACE_DEPTH = 16
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_op,
    input  logic [STEP_W-1:0]            cmd_count,
    input  logic [NUM_BP*ADDR_W-1:0]     bp_addr,
    input  logic [NUM_BP-1:0]            bp_en,
    input  logic [ADDR_W-1:0]            pc,
    output logic                         cpu_en,
    output logic                         halted,
    output logic [1:0]                   halt_cause,
    output logic                         trace_valid,
    input  logic                         trace_ready,
    output logic [ADDR_W-1:0]            trace_pc,
    output logic [$clog2(TRACE_DEPTH):0] trace_count,
    output logic                         trace_overflow
);

    localparam logic [STEP_W-1:0] C_STEP_ONE = STEP_W'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [STEP_W-1:0] r_cnt;
    logic [STEP_W-1:0] w_cnt_nxt;
    logic [1:0]        r_cause;
    logic [1:0]        w_cause_nxt;
    logic              r_skip;
    logic              w_skip_nxt;
    logic              w_accept;
    logic [NUM_BP-1:0] w_bp_match;
    logic              w_bp_hit;
    logic              w_flush;

    assign cmd_ready = ~RST;
    assign w_accept  = cmd_valid & cmd_ready;
    assign w_flush   = w_accept & (cmd_op == C_OP_CLEAR);

    for (genvar i = 0; i < NUM_BP; i++) begin : g_bp
        assign w_bp_match[i] = bp_en[i] & (bp_addr[i*ADDR_W +: ADDR_W] == pc);
    end

    assign w_bp_hit   = (|w_bp_match) & ~r_skip;
    assign cpu_en     = (r_state != ST_IDLE) & ~w_bp_hit;
    assign halted     = (r_state == ST_IDLE);
    assign halt_cause = r_cause;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_cause <= C_CAUSE_NONE;
            r_skip  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cause <= w_cause_nxt;
            r_skip  <= w_skip_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cause_nxt = r_cause;
        w_skip_nxt  = r_skip;

        if (r_state != ST_IDLE) begin
            w_skip_nxt = 1'b0;
            if (w_bp_hit) begin
                w_state_nxt = ST_IDLE;
                w_cause_nxt = C_CAUSE_BREAK;
            end else if (r_state == ST_STEP) begin
                w_cnt_nxt = r_cnt - C_STEP_ONE;
                if (r_cnt == C_STEP_ONE) begin
                    w_state_nxt = ST_IDLE;
                    w_cause_nxt = C_CAUSE_STEP_DONE;
                end
            end
        end

        // A command accepted this cycle overrides the progression above.
        if (w_accept) begin
            case (cmd_op)
                C_OP_HALT: begin
                    if (r_state != ST_IDLE)
                        w_cause_nxt = C_CAUSE_HOST;
                    w_state_nxt = ST_IDLE;
                end
                C_OP_STEP: begin
                    w_skip_nxt = 1'b1;
                    w_cnt_nxt  = cmd_count;
                    if (cmd_count == '0) begin
                        w_state_nxt = ST_IDLE;
                        w_cause_nxt = C_CAUSE_STEP_DONE;
                    end else begin
                        w_state_nxt = ST_STEP;
                    end
                end
                C_OP_RUN: begin
                    w_skip_nxt  = 1'b1;
                    w_state_nxt = ST_RUN;
                end
                default: begin
                    w_cause_nxt = C_CAUSE_NONE;
                end
            endcase
        end
    end

`ifdef CPU_STEP_CTRL_TRACE_EN
    logic w_fifo_empty;
    logic w_fifo_full_unused;

    assign trace_valid = ~w_fifo_empty;

    step_trace_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk        (CLK),
        .rst        (RST),
        .i_push     (cpu_en),
        .i_pop      (trace_valid & trace_ready),
        .i_flush    (w_flush),
        .i_data     (pc),
        .o_data     (trace_pc),
        .o_count    (trace_count),
        .o_full     (w_fifo_full_unused),
        .o_empty    (w_fifo_empty),
        .o_overflow (trace_overflow)
    );
`else
    logic w_trace_unused;

    assign w_trace_unused = trace_ready | w_flush;
    assign trace_valid    = 1'b0;
    assign trace_pc       = '0;
    assign trace_count    = '0;
    assign trace_overflow = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cpu_step_ctrl.sv
// ============================================================================
// Module      : tb_cpu_step_ctrl
// Description : Scoreboard bench for cpu_step_ctrl against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_step_ctrl;

`ifdef CPU_STEP_CTRL_TRACE_EN
    localparam bit TR = 1'b1;
`else
    localparam bit TR = 1'b0;
`endif
    localparam int DEPTH = 16;
    localparam logic [1:0] HALT = 2'd0, STEP = 2'd1, RUN = 2'd2, CLEAR = 2'd3;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [15:0] cmd_count = 16'd0;
    logic [63:0] bp_addr = 64'd0;
    logic [1:0]  bp_en = 2'b00;
    logic [31:0] pc = 32'd0;
    logic        cpu_en;
    logic        halted;
    logic [1:0]  halt_cause;
    logic        trace_valid;
    logic        trace_ready = 1'b0;
    logic [31:0] trace_pc;
    logic [4:0]  trace_count;
    logic        trace_overflow;

    cpu_step_ctrl #(
        .ADDR_W(32), .STEP_W(16), .NUM_BP(2), .TRACE_DEPTH(DEPTH)
    ) dut (
        .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_count(cmd_count), .bp_addr(bp_addr), .bp_en(bp_en),
        .pc(pc), .cpu_en(cpu_en), .halted(halted), .halt_cause(halt_cause),
        .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_pc(trace_pc),
        .trace_count(trace_count), .trace_overflow(trace_overflow)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          en;
        bit          hlt;
        bit   [1:0]  cause;
        bit          tv;
        int          tc;
        bit          ov;
        logic [31:0] tpc;
        bit          rdy;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model: "budget" is remaining instructions, negative = unlimited.
    bit          m_active, m_skip, m_ov;
    int          m_budget;
    bit   [1:0]  m_cause;
    logic [31:0] m_fifo[$];
    logic [31:0] m_pc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_hit();
        logic [31:0] a;
        if (m_skip) return 1'b0;
        for (int i = 0; i < 2; i++) begin
            a = bp_addr[i*32 +: 32];
            if (bp_en[i] && a == m_pc) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic m_reset();
        m_active = 0; m_skip = 0; m_ov = 0; m_budget = 0; m_cause = 0;
        m_fifo.delete(); m_pc = 32'd0;
    endtask

    function automatic exp_t m_expect(input bit in_rst);
        exp_t e;
        e.en    = m_active && !m_hit();
        e.hlt   = !m_active;
        e.cause = m_cause;
        e.tv    = TR && m_fifo.size() > 0;
        e.tc    = TR ? m_fifo.size() : 0;
        e.ov    = TR && m_ov;
        e.tpc   = (TR && m_fifo.size() > 0) ? m_fifo[0] : 32'd0;
        e.rdy   = !in_rst;
        return e;
    endfunction

    task automatic m_edge();
        bit hit, was, ex;
        logic [31:0] dummy;
        hit = m_hit();
        was = m_active;
        ex  = m_active && !hit;
        if (TR) begin
            if (trace_ready && m_fifo.size() > 0) dummy = m_fifo.pop_front();
            if (ex) begin
                if (m_fifo.size() < DEPTH) m_fifo.push_back(m_pc);
                else m_ov = 1;
            end
        end
        if (was) begin
            m_skip = 0;
            if (hit) begin
                m_active = 0; m_cause = 2;
            end else if (m_budget > 0) begin
                m_budget--;
                if (m_budget == 0) begin m_active = 0; m_cause = 1; end
            end
        end
        if (cmd_valid) begin
            case (cmd_op)
                HALT: begin if (was) m_cause = 3; m_active = 0; end
                STEP: begin
                    m_skip = 1;
                    if (cmd_count == 0) begin m_active = 0; m_cause = 1; end
                    else begin m_active = 1; m_budget = int'(cmd_count); end
                end
                RUN:  begin m_skip = 1; m_active = 1; m_budget = -1; end
                default: begin m_fifo.delete(); m_ov = 0; m_cause = 0; end
            endcase
        end
        if (ex) m_pc = m_pc + 32'd4;
    endtask

    // One clock cycle: drive at negedge, publish expectation, advance model at posedge.
    task automatic cyc(input bit v, input logic [1:0] op, input int cnt, input bit rdy, input bit r);
        @(negedge CLK);
        RST = r; cmd_valid = v; cmd_op = op; cmd_count = 16'(cnt); trace_ready = rdy;
        if (r) m_reset();
        pc = m_pc;
        #1;
        sb_q.push_back(m_expect(r));
        @(posedge CLK);
        if (!r) m_edge();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(0, HALT, 0, rdy, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("cpu_en", {31'd0, cpu_en}, {31'd0, e.en});
                chk("halted", {31'd0, halted}, {31'd0, e.hlt});
                chk("halt_cause", {30'd0, halt_cause}, {30'd0, e.cause});
                chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, e.rdy});
                chk("trace_valid", {31'd0, trace_valid}, {31'd0, e.tv});
                chk("trace_count", {27'd0, trace_count}, 32'(e.tc));
                chk("trace_overflow", {31'd0, trace_overflow}, {31'd0, e.ov});
                if (e.tv || !TR) chk("trace_pc", trace_pc, e.tpc);
            end
        end
    end

    initial begin : stim
        int cnt;
        m_reset();
        cyc(0, HALT, 0, 0, 1);
        cyc(0, HALT, 0, 0, 1);
        // STEP 3 from pc 0, then drain the trace
        cyc(1, STEP, 3, 0, 0);
        idle(5, 0);
        idle(4, 1);
        // Breakpoint at 0x10, RUN, then step past it
        cyc(0, HALT, 0, 1, 1);
        bp_addr[31:0] = 32'h10; bp_en = 2'b01;
        cyc(1, RUN, 0, 1, 0);
        idle(7, 1);
        cyc(1, STEP, 1, 1, 0);
        idle(4, 1);
        bp_en = 2'b00;
        // Overflow: STEP 20 with no pops, drain, then CLEAR
        cyc(0, HALT, 0, 0, 1);
        cyc(1, STEP, 20, 0, 0);
        idle(22, 0);
        idle(17, 1);
        cyc(1, STEP, 5, 0, 0);
        idle(6, 0);
        cyc(1, CLEAR, 0, 0, 0);
        idle(2, 0);
        // RUN then HALT five cycles later
        cyc(1, RUN, 0, 1, 0);
        idle(4, 1);
        cyc(1, HALT, 0, 1, 0);
        idle(3, 1);
        // STEP 10 interrupted by reset after four executions
        cyc(1, STEP, 10, 0, 0);
        idle(4, 0);
        cyc(0, HALT, 0, 0, 1);
        idle(2, 0);
        // STEP 0
        cyc(1, STEP, 0, 1, 0);
        idle(3, 1);
        // Randomised phase
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                bp_addr = {32'($urandom_range(0, 24) * 4), 32'($urandom_range(0, 24) * 4)};
                bp_en   = 2'($urandom_range(0, 3));
            end
            cnt = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 5));
            cyc($urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)), cnt,
                $urandom_range(0, 2) != 0, $urandom_range(0, 79) == 0);
        end
        @(negedge CLK);
        #5;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
